comparador_serial: RTL
======================

COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be an integer multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits compared per clock; SHALL satisfy 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 start  input  1  request a comparison; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; sampled on the edge that accepts start.
REQ-007 b  input  WIDTH  operand B; sampled on the edge that accepts start.
REQ-008 busy  output  1  high while in BUSY.
REQ-009 done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 aeqb  output  1  registered result: A equals B.
REQ-011 agtb  output  1  registered result: A greater than B.
REQ-012 altb  output  1  registered result: A less than B.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE; busy=1 only in BUSY, and done=1 only in DONE.
REQ-014 IDLE with start=1 at edge E0: capture a and b into internal shift registers, clear aeqb/agtb/altb, clear the digit counter, go to BUSY.
REQ-015 BUSY: each cycle compare the most-significant DIGIT bits of both shift registers as unsigned values.
REQ-016 BUSY with digits differing: set agtb or altb accordingly at the next edge, go to DONE (early termination).
REQ-017 BUSY with digits equal and not the last digit: shift both registers left by DIGIT, increment the counter, stay in BUSY.
REQ-018 BUSY with digits equal and the last digit (counter = WIDTH/DIGIT-1): set aeqb at the next edge, go to DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: with n = number of digits examined (1..WIDTH/DIGIT), done SHALL be high in the cycle following edge E0+n.
REQ-021 After done, exactly one of aeqb/agtb/altb SHALL be 1 and SHALL hold until the next accepted start.
REQ-022 All three result flags SHALL be 0 while in BUSY.
REQ-023 start SHALL be ignored in BUSY and DONE; there SHALL be no queueing.
REQ-024 Changes on a and b after E0 SHALL NOT affect the comparison in progress.

Reset
REQ-025 rst=1 at an edge: state goes to IDLE; busy, done, aeqb, agtb and altb go to 0; counter and shift registers are cleared.
REQ-026 rst SHALL take priority over start and over any in-progress comparison, including when it arrives mid-operation.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro COMPARADOR_SERIAL_SIGNED_EN defined: operands are two's complement; the MSB of a and b SHALL be inverted at capture, with no added latency.
REQ-029 Macro COMPARADOR_SERIAL_SIGNED_EN undefined: operands are unsigned; the MSB inversion logic SHALL NOT be present.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-030 a=0x1234, b=0x1234 -> done at E0+4, aeqb=1, agtb=0, altb=0.
REQ-031 a=0x1334, b=0x1234 -> agtb=1, n=2; a=0x1234, b=0x1235 -> altb=1, n=4.
REQ-032 a=0x8000, b=0x7FFF, n=1 -> unsigned build: agtb=1; build with COMPARADOR_SERIAL_SIGNED_EN: altb=1.
REQ-033 start pulsed and a/b changed every cycle during BUSY for a=0x00F0, b=0x00F0 -> one done only, aeqb=1.
REQ-034 rst asserted in the 2nd BUSY cycle -> next cycle all outputs 0 in IDLE; a new start with a=5, b=9 -> altb=1.
REQ-035 WIDTH=8, DIGIT=1: a=0x00, b=0x01 -> done at E0+8, altb=1.

Source files
------------

// File: rtl/comparador_serial.sv
// comparador_serial: serial magnitude comparator, most-significant digit first.
//
// Compares two WIDTH-bit operands DIGIT bits per clock, starting at the top
// digit, and stops at the first digit that differs. A comparison of equal
// operands takes WIDTH/DIGIT cycles in BUSY. A differing digit ends it early.
//
// Parameters:
//   WIDTH  operand width in bits (must be an integer multiple of DIGIT)
//   DIGIT  bits compared per clock (1 <= DIGIT <= WIDTH)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request a comparison; only honoured while idle
//   a, b   operands, captured on the edge that accepts start
//   busy   high while digits are being compared
//   done   one-cycle pulse when the result flags become valid
//   aeqb   registered result A == B
//   agtb   registered result A >  B
//   altb   registered result A <  B
//
// Build option:
//   COMPARADOR_SERIAL_SIGNED_EN  when defined, operands are two's complement.
//   Otherwise they are unsigned.

module comparador_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CntW-1:0]  cnt_q;

  // Operand values as loaded into the shift registers.
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

`ifdef COMPARADOR_SERIAL_SIGNED_EN
  // Flipping the sign bit maps two's complement ordering onto unsigned
  // ordering, so the digit comparator below stays purely unsigned.
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

  assign a_cap = a ^ MsbMask;
  assign b_cap = b ^ MsbMask;
`else
  assign a_cap = a;
  assign b_cap = b;
`endif

  // Current digit under comparison: always the top DIGIT bits.
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;

  assign dig_a = sa_q[WIDTH-1 -: DIGIT];
  assign dig_b = sb_q[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aeqb    <= 1'b0;
      agtb    <= 1'b0;
      altb    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            sa_q    <= a_cap;
            sb_q    <= b_cap;
            cnt_q   <= '0;
            aeqb    <= 1'b0;
            agtb    <= 1'b0;
            altb    <= 1'b0;
            busy    <= 1'b1;
            state_q <= StBusy;
          end
        end

        StBusy: begin
          if (dig_a != dig_b) begin
            // First differing digit decides the result; no need to look further.
            agtb    <= (dig_a > dig_b);
            altb    <= (dig_a < dig_b);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q == LastDigit) begin
            aeqb    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            sa_q  <= sa_q << DIGIT;
            sb_q  <= sb_q << DIGIT;
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StDone: begin
          // Result flags hold here and through IDLE until the next start.
          done    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
